// File: rtl/param_loader.sv
// Byte-stream command decoder for the scenario FSM's run-time parameter registers.
// Frames are A5, ADDR, VAL_HI, VAL_LO, CSUM, followed by a one-cycle commit with checksum, address and lock checks.
module param_loader #(
  parameter int PW                         = 16,
  parameter int TIMEOUT_CYCLES             = 1000,
  parameter int DEF_FG_OPEN_DELAY          = 100,
  parameter int DEF_DETECTOR_READY_TIMEOUT = 5000,
  parameter int DEF_PHASE_SHIFT            = 0,
  parameter int DEF_DETONATE_LEN           = 10,
  parameter int DEF_TRIGGER_LEN            = 10
) (
  input  logic          clk,
  input  logic          reset_signal,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic          scenario_busy,
  output logic [PW-1:0] fg_open_delay,
  output logic [PW-1:0] detector_ready_timeout,
  output logic [PW-1:0] phase_shift,
  output logic [PW-1:0] detonate_len,
  output logic [PW-1:0] trigger_len,
  output logic [4:0]    written_mask,
  output logic          params_complete,
  output logic          write_strobe,
  output logic          err_checksum,
  output logic          err_addr,
  output logic          err_locked,
  output logic          err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_SYNC, S_ADDR, S_VHI, S_VLO, S_CSUM, S_COMMIT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    addr_q, vhi_q, vlo_q, csum_q;
  logic [15:0]   raw;
  logic [PW-1:0] value;
  logic          accept, in_frame, timeout_hit, is_commit, bad_csum, bad_addr, do_write;

  assign raw = {vhi_q, vlo_q};

  generate
    if (PW > 16) begin : g_ext
      assign value = {{(PW-16){1'b0}}, raw};
    end else begin : g_trunc
      assign value = raw[PW-1:0];
    end
  endgenerate

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_signal) state <= S_SYNC;
    else              state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:   if (accept && rx_data == 8'hA5) state_nxt = S_ADDR;
      S_ADDR:   if (accept) state_nxt = S_VHI;    else if (timeout_hit) state_nxt = S_SYNC;
      S_VHI:    if (accept) state_nxt = S_VLO;    else if (timeout_hit) state_nxt = S_SYNC;
      S_VLO:    if (accept) state_nxt = S_CSUM;   else if (timeout_hit) state_nxt = S_SYNC;
      S_CSUM:   if (accept) state_nxt = S_COMMIT; else if (timeout_hit) state_nxt = S_SYNC;
      default:  state_nxt = S_SYNC;
    endcase
  end

  // Commit outcome is decided in priority order: checksum, address, lock, then write.
  always_comb begin
    rx_ready    = (state != S_COMMIT);
    accept      = rx_valid && rx_ready;
    in_frame    = (state == S_ADDR) || (state == S_VHI) || (state == S_VLO) || (state == S_CSUM);
    timeout_hit = in_frame && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES));
    is_commit   = (state == S_COMMIT);
    bad_csum    = (addr_q ^ vhi_q ^ vlo_q) != csum_q;
    bad_addr    = addr_q > 8'd4;
    do_write    = is_commit && !bad_csum && !bad_addr && !scenario_busy;
  end

  always_ff @(posedge clk) begin
    if (reset_signal) begin
      idle_cnt               <= '0;
      addr_q                 <= '0;
      vhi_q                  <= '0;
      vlo_q                  <= '0;
      csum_q                 <= '0;
      write_strobe           <= 1'b0;
      err_checksum           <= 1'b0;
      err_addr               <= 1'b0;
      err_locked             <= 1'b0;
      err_timeout            <= 1'b0;
      written_mask           <= '0;
      fg_open_delay          <= PW'(DEF_FG_OPEN_DELAY);
      detector_ready_timeout <= PW'(DEF_DETECTOR_READY_TIMEOUT);
      phase_shift            <= PW'(DEF_PHASE_SHIFT);
      detonate_len           <= PW'(DEF_DETONATE_LEN);
      trigger_len            <= PW'(DEF_TRIGGER_LEN);
    end else begin
      write_strobe <= do_write;
      err_checksum <= is_commit && bad_csum;
      err_addr     <= is_commit && !bad_csum && bad_addr;
      err_locked   <= is_commit && !bad_csum && !bad_addr && scenario_busy;
      err_timeout  <= timeout_hit;

      if (!in_frame || accept || timeout_hit) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + 1'b1;

      if (accept) begin
        case (state)
          S_ADDR:  addr_q <= rx_data;
          S_VHI:   vhi_q  <= rx_data;
          S_VLO:   vlo_q  <= rx_data;
          S_CSUM:  csum_q <= rx_data;
          default: ;
        endcase
      end

      if (do_write) begin
        case (addr_q[2:0])
          3'd0:    begin fg_open_delay          <= value; written_mask[0] <= 1'b1; end
          3'd1:    begin detector_ready_timeout <= value; written_mask[1] <= 1'b1; end
          3'd2:    begin phase_shift            <= value; written_mask[2] <= 1'b1; end
          3'd3:    begin detonate_len           <= value; written_mask[3] <= 1'b1; end
          default: begin trigger_len            <= value; written_mask[4] <= 1'b1; end
        endcase
      end
    end
  end

  assign params_complete = &written_mask;

endmodule

// File: doc/param_loader.md
# param_loader

Byte-stream command decoder that writes the run-time parameter registers of the synchronization block's scenario FSM: fg open delay, detector-ready timeout, phase shift, detonate length and trigger length. It sits between the host link's byte receiver and the parameter bus that the scenario FSM reads. It frames, checksums and range-checks each command, and it refuses writes while a scenario is running.

## Interface
Parameters:
- PW, 16, width of each parameter register
- TIMEOUT_CYCLES, 1000, maximum idle cycles between bytes inside a frame
- DEF_FG_OPEN_DELAY, 100, reset value of fg_open_delay
- DEF_DETECTOR_READY_TIMEOUT, 5000, reset value of detector_ready_timeout
- DEF_PHASE_SHIFT, 0, reset value of phase_shift
- DEF_DETONATE_LEN, 10, reset value of detonate_len
- DEF_TRIGGER_LEN, 10, reset value of trigger_len

Ports:
- clk, in, 1, single clock; all logic on rising edge
- reset_signal, in, 1, synchronous, active-high reset
- rx_data, in, 8, incoming byte
- rx_valid, in, 1, rx_data valid
- rx_ready, out, 1, loader can accept a byte
- scenario_busy, in, 1, scenario FSM active; blocks writes
- fg_open_delay, out, PW, parameter register, address 0
- detector_ready_timeout, out, PW, parameter register, address 1
- phase_shift, out, PW, parameter register, address 2
- detonate_len, out, PW, parameter register, address 3
- trigger_len, out, PW, parameter register, address 4
- written_mask, out, 5, bit i set once address i has been written since reset
- params_complete, out, 1, &written_mask
- write_strobe, out, 1, one-cycle pulse on a successful write
- err_checksum, err_addr, err_locked, err_timeout, out, 1 each, one-cycle error pulses

## Operation
- Frame format: 0xA5 (sync), ADDR, VAL_HI, VAL_LO, CSUM, where CSUM = ADDR ^ VAL_HI ^ VAL_LO.
- Value = {VAL_HI, VAL_LO}, truncated or zero-extended to PW.
- A byte is accepted on a rising edge when rx_valid && rx_ready.
- States:
  - SYNC: accepted bytes other than 0xA5 are discarded silently. 0xA5 -> ADDR.
  - ADDR, VHI, VLO: each accepted byte is latched and the state advances.
  - CSUM: accepted byte -> COMMIT.
  - COMMIT: lasts one cycle with rx_ready = 0, then -> SYNC.
- rx_ready = 1 in every state except COMMIT.
- COMMIT evaluates exactly one outcome, in priority order:
  1. Checksum mismatch -> err_checksum.
  2. ADDR > 4 -> err_addr.
  3. scenario_busy = 1, sampled in the COMMIT cycle -> err_locked.
  4. Otherwise: write the register, set its written_mask bit, pulse write_strobe.
- Rejected frames leave every register and written_mask unchanged.
- Inter-byte timeout: a counter runs in ADDR, VHI, VLO and CSUM.
  - It clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES without an accepted byte: state -> SYNC and err_timeout pulses once.
  - It is held at 0 in SYNC and COMMIT.
- A 0xA5 byte received mid-frame is data, not a resync.
- Reset (at any time, including mid-frame or in COMMIT):
  - state = SYNC, timeout counter = 0
  - registers = DEF_* values, written_mask = 0, params_complete = 0
  - all pulses 0, rx_ready = 1 in the cycle after reset deasserts
  - a partial frame is discarded with no error pulse

## Timing
- CSUM byte accepted at edge N: COMMIT is the state during cycle N..N+1.
- Register update, written_mask update and the write_strobe or error pulse are all registered at edge N+1. They are visible from N+1 and the pulse lasts exactly one cycle.
- Minimum frame period is 6 cycles: 5 bytes plus COMMIT. Back-to-back frames are accepted with no extra gap.
- err_timeout is visible one cycle after the edge at which the counter reaches TIMEOUT_CYCLES. The state is SYNC in that same cycle.
- At most one pulse output is high in any cycle.
- Register outputs change only at a successful COMMIT or at reset. They are glitch-free, stable and registered.

## Test plan
- Reset, then idle -> fg_open_delay = 100, detector_ready_timeout = 5000, phase_shift = 0, detonate_len = 10, trigger_len = 10; written_mask = 0; rx_ready = 1; no pulses.
- Bytes A5 02 01 F4 F7 back-to-back, scenario_busy = 0 -> phase_shift = 0x01F4 (500) and write_strobe high for one cycle, both one cycle after the CSUM edge; written_mask = 5'b00100; rx_ready low for exactly one cycle.
- Same frame with CSUM = F6 -> err_checksum pulses, phase_shift unchanged. Frame A5 07 00 01 06 -> err_addr pulses, no register changes.
- Frame A5 04 00 20 24 with scenario_busy = 1 during COMMIT -> err_locked, trigger_len stays 10. Repeat with busy = 0 -> trigger_len = 32.
- Send 00 FF, then A5 03, then idle for TIMEOUT_CYCLES -> the first two bytes are ignored, err_timeout pulses once, and a following valid frame A5 03 00 05 06 sets detonate_len = 5.
- Write addresses 0–4 in sequence -> params_complete rises with the fifth write_strobe. Assert reset_signal mid-frame (after A5 01) -> all registers return to DEF_*, written_mask = 0, no error pulse, and the next full frame is decoded correctly.
